// File: rtl/alu_seq_ctrl_if.sv
// Opcode package and the handshake/bus interface for the multi-byte ALU
// operation sequencer.
//
// alu_seq_pkg     : 4-bit ALU function codes shared by the sequencer,
//                   the ALU and the issuing side.
// alu_seq_ctrl_if : request channel (req_*), operand byte-pair channel
//                   (op*_), ALU drive/return (alu_*), result stream
//                   (res_*), architectural flags and the done pulse.
//   modport slave  - the sequencer's view
//   modport master - the issuing side / ALU / result consumer view
package alu_seq_pkg;
  localparam logic [3:0] ADD_FN  = 4'h0;
  localparam logic [3:0] ADDC_FN = 4'h1;
  localparam logic [3:0] SUB_FN  = 4'h2;
  localparam logic [3:0] SUBC_FN = 4'h3;
  localparam logic [3:0] AND_FN  = 4'h4;
  localparam logic [3:0] OR_FN   = 4'h5;
  localparam logic [3:0] XOR_FN  = 4'h6;
  localparam logic [3:0] MASK_FN = 4'h7;
  localparam logic [3:0] SHL_FN  = 4'h8;
  localparam logic [3:0] SHR_FN  = 4'h9;
  localparam logic [3:0] ROL_FN  = 4'hA;
  localparam logic [3:0] ROR_FN  = 4'hB;
endpackage

interface alu_seq_ctrl_if #(
  parameter int LW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [LW-1:0] req_len;
  logic          op_valid;
  logic          op_ready;
  logic [7:0]    opa_data;
  logic [7:0]    opb_data;
  logic [7:0]    alu_in1;
  logic [7:0]    alu_in2;
  logic          alu_cin;
  logic [3:0]    alu_opcode;
  logic [7:0]    alu_out;
  logic          alu_cout;
  logic          alu_z;
  logic [7:0]    res_data;
  logic          res_valid;
  logic          res_ready;
  logic          res_last;
  logic          flag_c;
  logic          flag_z;
  logic          done;

  modport slave (
    input  req_valid, req_op, req_len, op_valid, opa_data, opb_data,
           alu_out, alu_cout, alu_z, res_ready,
    output req_ready, op_ready, alu_in1, alu_in2, alu_cin, alu_opcode,
           res_data, res_valid, res_last, flag_c, flag_z, done
  );

  modport master (
    output req_valid, req_op, req_len, op_valid, opa_data, opb_data,
           alu_out, alu_cout, alu_z, res_ready,
    input  req_ready, op_ready, alu_in1, alu_in2, alu_cin, alu_opcode,
           res_data, res_valid, res_last, flag_c, flag_z, done
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-byte operation sequencer driving an 8-bit ALU.
// Accepts one request (opcode, length-1), streams operand byte-pairs
// LSB first through the ALU, chains carry/borrow between bytes, registers
// each result byte onto a one-entry output stream and updates the C/Z
// flags on the last byte.
//
// Ports:
//   clk - clock, all state on rising edge
//   rst - synchronous active-high reset
//   bus - alu_seq_ctrl_if.slave: request, operand, ALU, result, flags, done
module alu_seq_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LW      = $clog2(MAX_LEN)
) (
  input logic           clk,
  input logic           rst,
  alu_seq_ctrl_if.slave bus
);
  import alu_seq_pkg::*;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state;
  logic [3:0]    op_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] count;
  logic          run_z;     // AND of per-byte zero flags so far
  logic          carry_q;   // carry/borrow out of the previous byte

  logic accept;
  logic consume;
  logic first_byte;
  logic last_byte;

  assign bus.req_ready = (state == IDLE);
  // One-entry output register: a new byte may enter when the slot is empty
  // or is being drained this same cycle.
  assign bus.op_ready  = (state == RUN) && (!bus.res_valid || bus.res_ready);
  assign accept        = bus.op_valid && bus.op_ready;
  assign consume       = bus.res_valid && bus.res_ready;
  assign first_byte    = (count == '0);
  assign last_byte     = (count == len_q);

  // ALU drive: byte 0 of ADD/SUB starts a fresh chain, later bytes switch to
  // the carry-in form; ADDC/SUBC requests chain from the architectural flag.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // a value held, which would otherwise infer a latch.
    bus.alu_in1    = '0;
    bus.alu_in2    = '0;
    bus.alu_opcode = '0;
    bus.alu_cin    = 1'b0;
    if (state == RUN) begin
      bus.alu_in1    = bus.opa_data;
      bus.alu_in2    = bus.opb_data;
      bus.alu_opcode = op_q;
      case (op_q)
        ADD_FN: begin
          bus.alu_opcode = first_byte ? ADD_FN : ADDC_FN;
          bus.alu_cin    = first_byte ? 1'b0 : carry_q;
        end
        SUB_FN: begin
          bus.alu_opcode = first_byte ? SUB_FN : SUBC_FN;
          bus.alu_cin    = first_byte ? 1'b0 : carry_q;
        end
        ADDC_FN, SUBC_FN: begin
          bus.alu_cin = first_byte ? bus.flag_c : carry_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: all registers use non-blocking assignments so each one samples
  // the pre-edge value of every other, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous and overrides everything, including an
      // in-flight request; context registers are cleared too so a
      // post-reset state is fully deterministic.
      state         <= IDLE;
      op_q          <= '0;
      len_q         <= '0;
      count         <= '0;
      run_z         <= 1'b0;
      carry_q       <= 1'b0;
      bus.res_data  <= '0;
      bus.res_valid <= 1'b0;
      bus.res_last  <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            len_q <= bus.req_len;
            count <= '0;
            run_z <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (consume) bus.res_valid <= 1'b0;
          // A capture in the same cycle as a consume wins, keeping
          // res_valid high with the new byte.
          if (accept) begin
            bus.res_data  <= bus.alu_out;
            bus.res_valid <= 1'b1;
            bus.res_last  <= last_byte;
            carry_q       <= bus.alu_cout;
            run_z         <= run_z & bus.alu_z;
            count         <= count + 1'b1;
            if (last_byte) begin
              bus.flag_c <= bus.alu_cout;
              bus.flag_z <= run_z & bus.alu_z;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Only the final byte can be pending here.
          if (consume && bus.res_last) begin
            bus.res_valid <= 1'b0;
            bus.done      <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
